// File: rtl/ledmux_pkg.sv
// Shared definitions for the LED-mux SPI link.
//   MATRIX_BITS   : bits in one LED matrix (x or y)
//   FRAME_BITS    : bits per serial frame, {yMatrix, xMatrix}
//   HALF_CNT_BITS : width of the sck half-period counter
//   spi_state_t   : transmitter FSM states
package ledmux_pkg;

  localparam int unsigned MATRIX_BITS   = 72;
  localparam int unsigned FRAME_BITS    = 2 * MATRIX_BITS;
  localparam int unsigned HALF_CNT_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    FINISH
  } spi_state_t;

endpackage

// File: rtl/ledmux_spi_master_if.sv
// Frame handshake plus SPI wire bundle for the LED-mux link.
//   frame_data/frame_valid/frame_ready : parallel frame handshake from the host
//   sck/sdi/load                       : SPI mode-0 lines to the LED board
//   done                               : one-cycle end-of-frame pulse
// Modports:
//   master : the SPI transmitter (accepts frames, drives the wire)
//   slave  : the frame source / observer
interface ledmux_spi_master_if #(
  parameter int unsigned FRAME_BITS = ledmux_pkg::FRAME_BITS
);

  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  sck;
  logic                  sdi;
  logic                  load;
  logic                  done;

  modport master (
    input  frame_data,
    input  frame_valid,
    output frame_ready,
    output sck,
    output sdi,
    output load,
    output done
  );

  modport slave (
    output frame_data,
    output frame_valid,
    input  frame_ready,
    input  sck,
    input  sdi,
    input  load,
    input  done
  );

endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer for the SPI clock.
// Down-counter reloaded with DIV_HALF-1; tick_o is high while the count is 0,
// so a phase that restarts the timer on entry lasts exactly DIV_HALF cycles.
//   clk_i     : system clock
//   reset_i   : synchronous, active-high reset (count returns to 0)
//   restart_i : reload the count (asserted on every FSM state change)
//   tick_o    : terminal count reached
module spi_half_tick
  import ledmux_pkg::*;
#(
  parameter int unsigned DIV_HALF = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [HALF_CNT_BITS-1:0] Reload = HALF_CNT_BITS'(DIV_HALF - 1);

  logic [HALF_CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - HALF_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/ledmux_spi_master.sv
// LED-mux SPI frame transmitter.
// Accepts a FRAME_BITS-wide frame over a valid/ready handshake and shifts it out
// MSB-first in SPI mode 0. load frames the whole transfer, done pulses for one
// cycle afterwards. Every output is a flop fed from the next-state decode, so
// nothing combinational reaches the pins.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : frame handshake + SPI lines (master side)
// Parameters:
//   FRAME_BITS : bits per frame
//   DIV_HALF   : clk cycles per sck half-period (1..255)
module ledmux_spi_master #(
  parameter int unsigned FRAME_BITS = ledmux_pkg::FRAME_BITS,
  parameter int unsigned DIV_HALF   = 4
) (
  input  logic                clk,
  input  logic                reset,
  ledmux_spi_master_if.master bus
);

  import ledmux_pkg::*;

  localparam int unsigned      CntW    = $clog2(FRAME_BITS);
  localparam logic [CntW-1:0]  LastBit = CntW'(FRAME_BITS - 1);

  spi_state_t            state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;

  logic ready_q, ready_d;
  logic load_q, load_d;
  logic sck_q, sck_d;
  logic sdi_q, sdi_d;
  logic done_q, done_d;

  logic tick;
  logic restart;

  // Every phase is timed from its own entry.
  assign restart = (state_d != state_q);

  spi_half_tick #(
    .DIV_HALF (DIV_HALF)
  ) u_half_tick (
    .clk_i     (clk),
    .reset_i   (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Next state, shift register and bit counter.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        // frame_ready is high throughout IDLE, so valid alone completes the handshake.
        if (bus.frame_valid) begin
          shreg_d   = bus.frame_data;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_d = SCK_HI;
      end
      SCK_HI: begin
        if (tick) begin
          if (bit_cnt_q == LastBit) begin
            state_d = FINISH;
          end else begin
            // Shift on the falling edge so sdi only moves while sck is low.
            state_d   = SCK_LO;
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      SCK_LO: begin
        if (tick) state_d = SCK_HI;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they line up with it once registered.
  always_comb begin
    ready_d = (state_d == IDLE);
    load_d  = (state_d == SETUP) || (state_d == SCK_HI) || (state_d == SCK_LO);
    sck_d   = (state_d == SCK_HI);
    sdi_d   = load_d & shreg_d[FRAME_BITS-1];
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b1;
      load_q    <= 1'b0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      load_q    <= load_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      done_q    <= done_d;
    end
  end

  assign bus.frame_ready = ready_q;
  assign bus.load        = load_q;
  assign bus.sck         = sck_q;
  assign bus.sdi         = sdi_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_ledmux_spi_master.sv
// Two transmitters (DIV_HALF=1 and DIV_HALF=4) share one stimulus stream.
// A timeline model predicts every output from the cycle index since the
// handshake; a mode-0 receiver model rebuilds each frame from the wire.
module tb_ledmux_spi_master;

  localparam int unsigned FB = 144;
  localparam int unsigned D0 = 1;
  localparam int unsigned D1 = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [FB-1:0] frame_data = '0;
  logic          frame_valid = 1'b0;

  always #5 clk = ~clk;

  ledmux_spi_master_if #(.FRAME_BITS(FB)) bus0 ();
  ledmux_spi_master_if #(.FRAME_BITS(FB)) bus1 ();

  assign bus0.frame_data  = frame_data;
  assign bus0.frame_valid = frame_valid;
  assign bus1.frame_data  = frame_data;
  assign bus1.frame_valid = frame_valid;

  ledmux_spi_master #(.FRAME_BITS(FB), .DIV_HALF(D0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.master)
  );

  ledmux_spi_master #(.FRAME_BITS(FB), .DIV_HALF(D1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic ok,
                       input logic [FB-1:0] act, input logic [FB-1:0] exp);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned dh(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  // Hand-computed load-high lengths: 2*144*1 and 2*144*4.
  function automatic int unsigned lit_len(input int i);
    return (i == 0) ? 288 : 1152;
  endfunction

  // Expected {ready, load, sck, sdi, done} at cycle k after the handshake.
  function automatic logic [4:0] expect_out(input int unsigned d, input bit busy,
                                            input int unsigned k, input logic [FB-1:0] f);
    int unsigned p;
    if (!busy) return 5'b10000;
    if (k > 2 * FB * d) return 5'b00001;
    p = (k - 1) / d;  // half-period index: 0 = setup, odd = sck high
    return {1'b0, 1'b1, p[0], f[FB-1-p/2], 1'b0};
  endfunction

  // Timeline model, advanced on each rising edge.
  bit            m_busy [2];
  int unsigned   m_k    [2];
  logic [FB-1:0] m_frame[2];

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 1'b0;
        m_k[i]    = 0;
      end else if (!m_busy[i]) begin
        if (frame_valid) begin
          m_busy[i]  = 1'b1;
          m_k[i]     = 1;
          m_frame[i] = frame_data;
        end
      end else if (m_k[i] > 2 * FB * dh(i)) begin
        m_busy[i] = 1'b0;
        m_k[i]    = 0;
      end else begin
        m_k[i]++;
      end
    end
  end

  // Receiver / timing monitor state.
  bit            chk_en = 1'b0;
  bit            b2b    = 1'b0;
  logic [4:0]    obs   [2];
  logic [4:0]    exp_o [2];
  logic          prev_load[2], prev_sck[2], prev_sdi[2];
  int unsigned   hi_len[2], lo_len[2], since_load[2], since_rise[2], sdi_stable[2];
  int unsigned   rises[2], dones[2], b2b_dones[2], gap_checks[2];
  logic [FB-1:0] rx[2], rx_last[2];

  task automatic mon(input int i, input logic [4:0] o);
    logic ld, sk, sd, dn;
    ld = o[3];
    sk = o[2];
    sd = o[1];
    dn = o[0];
    since_load[i]++;
    since_rise[i]++;
    if (ld && !prev_load[i]) begin
      if (b2b && b2b_dones[i] >= 1) begin
        gap_checks[i]++;
        check($sformatf("load gap dut%0d", i), lo_len[i] == 2, lo_len[i], 2);
      end
      lo_len[i] = 0; hi_len[i] = 0; since_load[i] = 0;
      rises[i] = 0; rx[i] = '0; sdi_stable[i] = 0;
    end
    if (!ld && prev_load[i]) lo_len[i] = 0;
    if (ld) hi_len[i]++;
    else lo_len[i]++;
    if (sd !== prev_sdi[i]) begin
      if (ld && prev_load[i])
        check($sformatf("sdi hold dut%0d", i), since_rise[i] >= dh(i), since_rise[i], dh(i));
      sdi_stable[i] = 0;
    end else begin
      sdi_stable[i]++;
    end
    if (sk && !prev_sck[i]) begin
      rises[i]++;
      rx[i] = {rx[i][FB-2:0], sd};
      check($sformatf("sdi setup dut%0d", i), sdi_stable[i] >= dh(i), sdi_stable[i], dh(i));
      if (rises[i] == 1)
        check($sformatf("first sck rise dut%0d", i), since_load[i] == dh(i), since_load[i],
              dh(i));
      since_rise[i] = 0;
    end
    if (dn) begin
      dones[i]++;
      if (b2b) b2b_dones[i]++;
      check($sformatf("sck rises dut%0d", i), rises[i] == FB, rises[i], FB);
      check($sformatf("rx frame dut%0d", i), rx[i] === m_frame[i], rx[i], m_frame[i]);
      check($sformatf("load length dut%0d", i), hi_len[i] == lit_len(i), hi_len[i], lit_len(i));
      rx_last[i] = rx[i];
    end
    prev_load[i] = ld;
    prev_sck[i]  = sk;
    prev_sdi[i]  = sd;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      obs[0] = {bus0.frame_ready, bus0.load, bus0.sck, bus0.sdi, bus0.done};
      obs[1] = {bus1.frame_ready, bus1.load, bus1.sck, bus1.sdi, bus1.done};
      for (int i = 0; i < 2; i++) begin
        exp_o[i] = expect_out(dh(i), m_busy[i], m_k[i], m_frame[i]);
        check($sformatf("outputs dut%0d {ready,load,sck,sdi,done}", i), obs[i] === exp_o[i],
              obs[i], exp_o[i]);
        mon(i, obs[i]);
      end
    end
  end

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] v = '0;
    for (int i = 0; i < 5; i++) v = {v[FB-33:0], $urandom()};
    return v;
  endfunction

  // Called just after a negedge with both DUTs idle.
  task automatic send(input logic [FB-1:0] f);
    frame_data  = f;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    check("load rise dut0", bus0.load === 1'b1, bus0.load, 1);
    check("ready fall dut1", bus1.frame_ready === 1'b0, bus1.frame_ready, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus0.frame_ready === 1'b1 && bus1.frame_ready === 1'b1) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("idle wait", n < 4000, n, 4000);
  endtask

  task automatic expect_frame(input string name, input logic [FB-1:0] f);
    check({name, " dut0"}, rx_last[0] === f, rx_last[0], f);
    check({name, " dut1"}, rx_last[1] === f, rx_last[1], f);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FB-1:0] fa, fb, fc, fr, f;
    int unsigned   d0_before, d1_before, nd;

    fa = {72'hFF00FF00FF00FF00FF, 72'h0};
    fb = rand_frame();
    fc = rand_frame();
    fr = 144'h123456789ABCDEF0_0FEDCBA987654321_A5C3;

    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle hold.
    repeat (100) @(negedge clk);
    check("idle outputs dut0", {bus0.frame_ready, bus0.load, bus0.sck, bus0.done} === 4'b1000,
          {bus0.frame_ready, bus0.load, bus0.sck, bus0.done}, 4'b1000);
    check("idle outputs dut1", {bus1.frame_ready, bus1.load, bus1.sck, bus1.done} === 4'b1000,
          {bus1.frame_ready, bus1.load, bus1.sck, bus1.done}, 4'b1000);

    // y = FF00.., x = 0.
    d0_before = dones[0];
    d1_before = dones[1];
    send(fa);
    wait_idle();
    expect_frame("frame A", fa);
    check("done pulses A dut0", dones[0] - d0_before == 1, dones[0] - d0_before, 1);
    check("done pulses A dut1", dones[1] - d1_before == 1, dones[1] - d1_before, 1);

    // Alternating pattern, first bit on the wire is 1.
    frame_data  = {36{4'hA}};
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    check("first bit AAAA dut1", bus1.sdi === 1'b1, bus1.sdi, 1);
    wait_idle();
    f = {36{4'hA}};
    expect_frame("frame AAAA", f);

    // New frame offered mid-transfer is ignored.
    send(fb);
    repeat (100) @(negedge clk);
    frame_data  = fc;
    frame_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("ready low mid-frame dut0", bus0.frame_ready === 1'b0, bus0.frame_ready, 0);
      check("ready low mid-frame dut1", bus1.frame_ready === 1'b0, bus1.frame_ready, 0);
    end
    frame_valid = 1'b0;
    frame_data  = rand_frame();
    wait_idle();
    expect_frame("frame B intact", fb);
    send(fc);
    wait_idle();
    expect_frame("frame C after done", fc);

    // Reset part-way through a frame, then a clean frame.
    send(rand_frame());
    repeat (110) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset outputs dut0", {bus0.frame_ready, bus0.load, bus0.sck, bus0.sdi, bus0.done}
          === 5'b10000, {bus0.frame_ready, bus0.load, bus0.sck, bus0.sdi, bus0.done}, 5'b10000);
    check("reset outputs dut1", {bus1.frame_ready, bus1.load, bus1.sck, bus1.sdi, bus1.done}
          === 5'b10000, {bus1.frame_ready, bus1.load, bus1.sck, bus1.sdi, bus1.done}, 5'b10000);
    reset = 1'b0;
    send(fr);
    wait_idle();
    expect_frame("frame after reset", fr);

    // Random frames with random valid/data noise while busy.
    for (int r = 0; r < 6; r++) begin
      f = rand_frame();
      send(f);
      repeat (200) begin
        frame_valid = 1'($urandom_range(0, 1));
        frame_data  = rand_frame();
        @(negedge clk);
      end
      frame_valid = 1'b0;
      wait_idle();
      check("random frame dut1", rx_last[1] === f, rx_last[1], f);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Back-to-back with valid held high.
    b2b         = 1'b1;
    frame_data  = fa;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_data = fc;
    nd = 0;
    for (int n = 0; n < 4000 && nd < 2; n++) begin
      @(negedge clk);
      if (bus1.done === 1'b1) nd++;
    end
    frame_valid = 1'b0;
    check("b2b done pulses seen dut1", nd == 2, nd, 2);
    wait_idle();
    check("b2b done count dut1", b2b_dones[1] == 2, b2b_dones[1], 2);
    check("b2b gap checked dut1", gap_checks[1] >= 1, gap_checks[1], 1);
    check("b2b second frame dut1", rx_last[1] === fc, rx_last[1], fc);
    b2b = 1'b0;

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
